// File: rtl/rv_pkg.sv
// Shared RV32I core definitions: widths, reset PC, bubble encoding and the IF/ID payload type.
package rv_pkg;

  localparam int unsigned     XLEN      = 32;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            misalign;
  } if_id_t;

  function automatic if_id_t if_id_bubble();
    if_id_t b;
    b.valid    = 1'b0;
    b.pc       = '0;
    b.instr    = NOP_INSTR;
    b.misalign = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// Single-entry hold buffer that parks the in-flight fetch while the IF/ID register is stalled.
module fetch_skid import rv_pkg::*; (
  input  logic            clk,
  input  logic            rst,
  input  logic            capture_i,
  input  logic            drain_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (capture_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      instr_d = instr_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
    pc_q    <= pc_d;
    instr_q <= instr_d;
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, one-cycle-latency imem request and IF/ID register.
// Optional feature: FETCH_MISALIGN_CHECK_EN flags misaligned redirect targets.
module fetch_stage import rv_pkg::*; (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_en_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [31:0]     imem_rdata_i,
  output logic            id_valid_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [31:0]     id_instr_o
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic            id_misalign_o
`endif
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_valid_q, req_valid_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  if_id_t          id_q, id_d;
  logic [XLEN-1:0] target_pc;
  logic            fetch_ok;
  logic            skid_capture, skid_drain, skid_flush;
  logic            hold_valid;
  logic [XLEN-1:0] hold_pc;
  logic [31:0]     hold_instr;

`ifdef FETCH_MISALIGN_CHECK_EN
  // Misaligned redirect: two bubbles, one flagged entry, then fetch stays parked.
  localparam logic [1:0] MisIdle  = 2'd0;
  localparam logic [1:0] MisWait1 = 2'd1;
  localparam logic [1:0] MisWait2 = 2'd2;
  localparam logic [1:0] MisDead  = 2'd3;
  logic [1:0] mis_q, mis_d;

  assign target_pc     = redirect_pc_i;
  assign fetch_ok      = (mis_q == MisIdle);
  assign id_misalign_o = id_q.misalign;
`else
  logic unused_misalign;

  assign target_pc       = redirect_pc_i & ~XLEN'(3);
  assign fetch_ok        = 1'b1;
  assign unused_misalign = id_q.misalign;
`endif

  fetch_skid u_skid (
    .clk      (clk),
    .rst      (rst),
    .capture_i(skid_capture),
    .drain_i  (skid_drain),
    .flush_i  (skid_flush),
    .pc_i     (req_pc_q),
    .instr_i  (imem_rdata_i),
    .valid_o  (hold_valid),
    .pc_o     (hold_pc),
    .instr_o  (hold_instr)
  );

  always_comb begin
    pc_d         = pc_q;
    req_valid_d  = req_valid_q;
    req_pc_d     = req_pc_q;
    id_d         = id_q;
    imem_en_o    = 1'b0;
    skid_capture = 1'b0;
    skid_drain   = 1'b0;
    skid_flush   = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    mis_d        = mis_q;
`endif
    if (rst) begin
      // state is reset in the flops; only imem_en_o must stay low here
    end else if (redirect_i) begin
      pc_d        = target_pc;
      req_valid_d = 1'b0;
      skid_flush  = 1'b1;
      id_d        = if_id_bubble();
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_d       = (target_pc[1:0] != 2'b00) ? MisWait1 : MisIdle;
`endif
    end else if (stall_i) begin
      skid_capture = req_valid_q;
      req_valid_d  = 1'b0;
    end else if (fetch_ok) begin
      imem_en_o   = 1'b1;
      pc_d        = pc_q + XLEN'(4);
      req_valid_d = 1'b1;
      req_pc_d    = pc_q;
      if (hold_valid) begin
        id_d       = '{valid: 1'b1, pc: hold_pc, instr: hold_instr, misalign: 1'b0};
        skid_drain = 1'b1;
      end else if (req_valid_q) begin
        id_d = '{valid: 1'b1, pc: req_pc_q, instr: imem_rdata_i, misalign: 1'b0};
      end else begin
        id_d = if_id_bubble();
      end
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    else begin
      req_valid_d = 1'b0;
      id_d        = if_id_bubble();
      if (mis_q == MisWait1) begin
        mis_d = MisWait2;
      end else if (mis_q == MisWait2) begin
        id_d  = '{valid: 1'b1, pc: pc_q, instr: NOP_INSTR, misalign: 1'b1};
        mis_d = MisDead;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
      req_pc_q    <= '0;
      id_q        <= if_id_bubble();
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_q       <= MisIdle;
`endif
    end else begin
      pc_q        <= pc_d;
      req_valid_q <= req_valid_d;
      req_pc_q    <= req_pc_d;
      id_q        <= id_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_q       <= mis_d;
`endif
    end
  end

  assign imem_addr_o = pc_q;
  assign id_valid_o  = id_q.valid;
  assign id_pc_o     = id_q.pc;
  assign id_instr_o  = id_q.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random stall/redirect/reset traffic.
module tb_fetch_stage;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] tgt = '0;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        id_misalign;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: next fetch address, fetched-but-undelivered PCs, and IF/ID contents.
  logic [31:0] m_pc;
  logic [31:0] pend[$];
  logic        m_valid;
  logic [31:0] m_idpc;
  logic [31:0] m_instr;

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall),
    .redirect_i   (redir),
    .redirect_pc_i(tgt),
    .imem_en_o    (imem_en),
    .imem_addr_o  (imem_addr),
    .imem_rdata_i (imem_rdata),
    .id_valid_o   (id_valid),
    .id_pc_o      (id_pc),
    .id_instr_o   (id_instr)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .id_misalign_o(id_misalign)
`endif
  );

  always #5 clk = ~clk;

  // Instruction word is a scramble of its address so pc/instr mix-ups are visible.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  always @(posedge clk) imem_rdata <= imem_en ? mem_f(imem_addr) : 32'hDEAD_BEEF;

  function automatic logic [97:0] act_vec();
    return {imem_en, imem_en ? imem_addr : 32'h0, id_valid, id_valid ? id_pc : 32'h0, id_instr};
  endfunction

  function automatic logic [97:0] exp_vec();
    logic en_e;
    en_e = !rst && !redir && !stall;
    return {en_e, en_e ? m_pc : 32'h0, m_valid, m_valid ? m_idpc : 32'h0, m_instr};
  endfunction

  task automatic model_bubble();
    m_valid = 1'b0;
    m_idpc  = '0;
    m_instr = NOP_INSTR;
  endtask

  task automatic model_next();
    if (rst) begin
      m_pc = RESET_PC;
      pend.delete();
      model_bubble();
    end else if (redir) begin
      m_pc = tgt & ~32'h3;
      pend.delete();
      model_bubble();
    end else if (!stall) begin
      if (pend.size() > 0) begin
        m_valid = 1'b1;
        m_idpc  = pend.pop_front();
        m_instr = mem_f(m_idpc);
      end else begin
        model_bubble();
      end
      pend.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic apply(input logic r, input logic s, input logic d, input logic [31:0] t);
    rst   = r;
    stall = s;
    redir = d;
    tgt   = t;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL reset cyc %0d: got %h want %h", i, act_vec(), exp_vec());
      end
      model_next();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_run();
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL run cyc %0d: got %h want %h", i, act_vec(), exp_vec());
      end
      model_next();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 13; i++) begin
      apply(1'b0, (i >= 5 && i < 8), 1'b0, 32'h0);
      @(negedge clk);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL stall cyc %0d: got %h want %h", i, act_vec(), exp_vec());
      end
      model_next();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect();
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, 1'b0, (i == 0), 32'h200);
      @(negedge clk);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL redirect cyc %0d: got %h want %h", i, act_vec(), exp_vec());
      end
      model_next();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect_stall();
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, (i <= 2), (i == 2), 32'h80);
      @(negedge clk);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL redir_stall cyc %0d: got %h want %h", i, act_vec(), exp_vec());
      end
      model_next();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_stall();
    for (int i = 0; i < 10; i++) begin
      apply((i == 5), (i >= 3 && i <= 5), 1'b0, 32'h0);
      @(negedge clk);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL rst_stall cyc %0d: got %h want %h", i, act_vec(), exp_vec());
      end
      model_next();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, 1'b0, (i == 0), 32'hFFFF_FFF8);
      @(negedge clk);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL wrap cyc %0d: got %h want %h", i, act_vec(), exp_vec());
      end
      model_next();
      @(posedge clk); #1;
    end
  endtask

`ifdef FETCH_MISALIGN_CHECK_EN
  task automatic test_misalign();
    logic exp_m;
    for (int i = 0; i < 7; i++) begin
      apply(1'b0, 1'b0, (i == 0), 32'h102);
      @(negedge clk);
      exp_m = (i == 3);
      if (i >= 1) begin
        n_checks++;
        if (imem_en !== 1'b0 || id_misalign !== exp_m || id_valid !== exp_m ||
            (exp_m && id_pc !== 32'h102)) begin
          n_errors++;
          $display("FAIL misalign cyc %0d: got en=%b mis=%b v=%b pc=%h want en=0 mis=%b v=%b",
                   i, imem_en, id_misalign, id_valid, id_pc, exp_m, exp_m);
        end
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b0, (i == 0), 32'h100);
      @(negedge clk);
      if (i >= 1) begin
        n_checks++;
        if (act_vec() !== exp_vec()) begin
          n_errors++;
          $display("FAIL misalign_resume cyc %0d: got %h want %h", i, act_vec(), exp_vec());
        end
      end
      model_next();
      @(posedge clk); #1;
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] t;
    for (int i = 0; i < 400; i++) begin
      t = ($urandom_range(7) == 0) ? 32'hFFFF_FFF0 : ($urandom & ~32'h3);
      apply(($urandom_range(63) == 0), ($urandom_range(3) == 0), ($urandom_range(9) == 0), t);
      @(negedge clk);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL random cyc %0d: got %h want %h", i, act_vec(), exp_vec());
      end
      model_next();
      @(posedge clk); #1;
    end
  endtask

  initial begin
    m_pc = RESET_PC;
    pend.delete();
    model_bubble();
    @(posedge clk); #1;
    test_reset();
    test_run();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_reset_mid_stall();
    test_wrap();
`ifdef FETCH_MISALIGN_CHECK_EN
    test_misalign();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RV32I core: owns the PC, drives a synchronous one-cycle-latency instruction memory, and presents the IF/ID pipeline register to decode. It sits directly upstream of the hazard/forwarding logic: it consumes that unit's stall and the EX-stage branch redirect, and guarantees that no fetched instruction is lost or duplicated across stalls.

## Interface
- XLEN, 32, datapath/address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- stall_i  in  1  hazard stall: hold PC and IF/ID
- redirect_i  in  1  taken branch/jump from EX; overrides stall_i
- redirect_pc_i  in  XLEN  redirect target
- imem_en_o  out  1  fetch request this cycle
- imem_addr_o  out  XLEN  fetch address (= pc_q)
- imem_rdata_i  in  32  instruction, valid the cycle after a request
- id_valid_o  out  1  IF/ID holds a real instruction
- id_pc_o  out  XLEN  PC of IF/ID instruction
- id_instr_o  out  32  IF/ID instruction
- id_misalign_o  out  1  present only with FETCH_MISALIGN_CHECK_EN

## Operation
- State: pc_q, req_valid_q/req_pc_q (request in flight), hold_valid_q/hold_pc_q/hold_instr_q (skid entry), id_* registers.
- Reset: pc_q=RESET_PC, req_valid_q=0, hold_valid_q=0, id_valid_o=0, id_pc_o=0, id_instr_o=NOP_INSTR, id_misalign_o=0; imem_en_o=0 during reset.
- Priority per cycle: rst > redirect_i > stall_i > run.
- Run: imem_en_o=1, imem_addr_o=pc_q; pc_q+=4 (mod 2^XLEN, wraps silently); req_valid_q<=1, req_pc_q<=pc_q. IF/ID loads hold entry if hold_valid_q (then clears it), else imem_rdata_i/req_pc_q if req_valid_q, else bubble (valid 0, NOP_INSTR).
- Stall: imem_en_o=0; pc_q and id_* hold. If req_valid_q, capture imem_rdata_i/req_pc_q into hold entry, hold_valid_q<=1; req_valid_q<=0. hold and req never both valid.
- Redirect: imem_en_o=0; pc_q<=redirect_pc_i; req_valid_q<=0, hold_valid_q<=0 (in-flight/held instruction discarded); IF/ID <= bubble.
- Redirect+stall same cycle: redirect wins; stall ignored.

## Timing
- Reset released before cycle 0: RESET_PC issued cycle 0, first id_valid_o=1 in cycle 2.
- Steady state: one instruction per cycle, no bubbles.
- Stall of k cycles: IF/ID frozen k cycles; release cycle loads held instruction while issuing next fetch — zero extra bubbles.
- Redirect in cycle N: bubble at IF/ID cycles N+1, N+2; target instruction valid cycle N+3.
- rst mid-stall or mid-redirect: full reset values next cycle; hold entry discarded.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: redirect with redirect_pc_i[1:0]!=0 sets a sticky misalign state; after the normal redirect bubbles, IF/ID presents id_valid_o=1, id_pc_o=redirect_pc_i, id_instr_o=NOP_INSTR, id_misalign_o=1 once, then issues no fetches (imem_en_o=0, bubbles) until next redirect or rst. Stall holds this entry like any other.
- Not defined: port absent; redirect_pc_i[1:0] forced to 2'b00.

## Structure
- Shared package rv_pkg: XLEN, NOP_INSTR, RESET_PC, if_id_t struct (valid, pc, instr, misalign).
- Sub-module fetch_skid: single-entry hold buffer (capture, drain, flush inputs; valid/pc/instr out).

## Test plan
- Reset then run, memory returns instr = addr: id_pc_o 0x0,0x4,0x8 from cycle 2, id_instr_o matching, no gaps.
- Stall 3 cycles at PC 0x10 in flight: id_* frozen at 0xC; after release 0x10, 0x14 consecutive, none dropped/duplicated.
- Redirect to 0x200 in cycle N: bubbles N+1, N+2 (id_instr_o=0x13, valid 0); 0x200 at N+3, 0x204 at N+4.
- Redirect and stall together while hold valid: hold discarded, target 0x80 appears at N+3.
- rst asserted during stall with hold valid: next cycle all outputs at reset values; fetch restarts at RESET_PC.
- Macro on, redirect to 0x102: id_misalign_o=1 with id_pc_o=0x102 once, imem_en_o stays 0 until redirect to 0x100 resumes fetch.
